sync_frame_tx: RTL and testbench
================================

// Module: sync_frame_tx
// PURPOSE
//  Serial frame transmitter: sends the 1001 sync sequence, then a parallel data word
//  MSB-first, one bit per clk. It is the sending end for the team's 1001 sequence
//  detectors. Drives the detector's x input directly; one upstream start/ready handshake.
// PARAMETERS
//  DATA_W   8        payload width in bits (2..32)
//  SYNC_W   4        sync pattern width in bits (1..8)
//  SYNC     4'b1001  sync pattern, sent MSB-first before the payload
// PORTS
//  clk       input   1       clock, rising edge
//  reset     input   1       asynchronous, active-low reset
//  start     input   1       request to send a frame; sampled only while ready=1
//  data_in   input   DATA_W  payload; captured on the edge where start&ready
//  ready     output  1       1 = idle, a frame request is accepted
//  busy      output  1       1 = frame in progress (SYNC, DATA, PAR or DONE)
//  tx_bit    output  1       serial bit; 0 whenever tx_valid=0
//  tx_valid  output  1       1 = tx_bit carries a frame bit this cycle
//  done      output  1       one-cycle pulse after the last frame bit
// BEHAVIOUR
//  Reset values: ready=1, busy=0, tx_bit=0, tx_valid=0, done=0, state=IDLE,
//   bit counter=0, shift register=0.
//  Reset is asynchronous: asserting it mid-frame aborts the frame at once.
//   No partial frame resumes and done is not pulsed.
//  States (registered; 3-bit encoding):
//   IDLE -> SYNC -> DATA -> [PAR] -> DONE -> IDLE.
//  IDLE
//   ready=1, busy=0. On edge with start=1: latch data_in into shift reg,
//   load counter=SYNC_W-1, go SYNC.
//   start=0 stays IDLE.
//  SYNC
//   tx_valid=1, tx_bit=SYNC[counter]. Counter decrements each edge.
//   At counter=0: load counter=DATA_W-1, go DATA.
//  DATA
//   tx_valid=1, tx_bit=shift[DATA_W-1]. Shift left, fill 0 each edge.
//   At counter=0: go PAR if enabled, else DONE.
//  PAR (only with option)
//   tx_valid=1, tx_bit=even parity (XOR) of the latched payload. Next: DONE.
//  DONE
//   tx_valid=0, tx_bit=0, done=1, busy=1, ready=0. Next: IDLE.
//  Latency: start accepted at edge N; first sync bit valid from edge N+1.
//   Frame occupies SYNC_W+DATA_W(+1) consecutive tx_valid cycles, with no gaps.
//  Throughput: at most one frame per SYNC_W+DATA_W(+1)+2 cycles.
//   Back-to-back start held high re-launches on the IDLE cycle after DONE.
//  start or data_in changes while busy=1 are ignored.
//   The latched payload is stable for the whole frame.
//  ready/busy are decoded from state; all other outputs are registered or
//   glitch-free decodes of state.
//  Counter width: $clog2(max(SYNC_W,DATA_W)); no wrap-around beyond the loaded value.
//  Payload equal to SYNC is legal; no bit stuffing is performed.
// CONFIGURATION
//  SYNC_FRAME_TX_PARITY_EN defined:
//   PAR state compiled in; one even-parity bit follows the payload.
//  Not defined:
//   PAR state, parity logic and its encoding are absent; DATA goes straight to DONE.
// TESTING
//  1. Reset low 2 cycles, release; start=0 for 5 cycles
//     -> ready=1, tx_valid=0, tx_bit=0, done=0 throughout.
//  2. start=1 for 1 cycle, data_in=8'hA5 -> tx_bit stream 1,0,0,1,1,0,1,0,0,1,0,1
//     with tx_valid=1 for 12 cycles, then done=1 for 1 cycle, then ready=1.
//  3. With PARITY_EN, data_in=8'hA5 -> 13th bit=0; data_in=8'h07 -> 13th bit=1;
//     done pulses 1 cycle later.
//  4. Loop detector (1001 Mealy) on tx_bit with 8'h00 payload
//     -> y=1 exactly once, on the 4th bit of the frame.
//  5. start held 1 and data_in changed to 8'hFF mid-frame
//     -> frame keeps A5 bits; second frame starts 1 cycle after done, carries FF.
//  6. Reset asserted during DATA bit 3 -> same-cycle tx_valid=0, busy=0, ready=1;
//     no done pulse; next start sends a full frame.

Source files
------------

// File: rtl/sync_frame_tx_if.sv
// Upstream handshake and serial output bundle for sync_frame_tx.
// master = frame source / bit consumer side, slave = the transmitter itself.
interface sync_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              busy;
    logic              tx_bit;
    logic              tx_valid;
    logic              done;

    modport master (
        output start, data_in,
        input  ready, busy, tx_bit, tx_valid, done
    );

    modport slave (
        input  start, data_in,
        output ready, busy, tx_bit, tx_valid, done
    );
endinterface

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: SYNC pattern then payload MSB-first, one bit per clk.
// Optional trailing even-parity bit when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1001
) (
    input  logic          clk,
    input  logic          reset,
    sync_frame_tx_if.slave bus
);

    localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
`ifdef SYNC_FRAME_TX_PARITY_EN
        ST_PAR  = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_bit_q, tx_bit_d;
    logic              tx_valid_q, tx_valid_d;
    logic              done_q, done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Selects SYNC[idx] without an index wider than the pattern itself.
    function automatic logic sync_bit(input logic [CNT_W-1:0] idx);
        sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (idx == CNT_W'(i)) sync_bit = SYNC[i];
        end
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef SYNC_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d = bus.data_in;
                    cnt_d   = CNT_W'(SYNC_W - 1);
`ifdef SYNC_FRAME_TX_PARITY_EN
                    par_d   = ^bus.data_in;
`endif
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                if (cnt_q == '0) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            ST_PAR:  state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial outputs are computed from the next state so they leave a flop, not a decoder.
    always_comb begin
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            ST_SYNC: begin
                tx_valid_d = 1'b1;
                tx_bit_d   = sync_bit(cnt_d);
            end
            ST_DATA: begin
                tx_valid_d = 1'b1;
                tx_bit_d   = shift_d[DATA_W-1];
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            ST_PAR: begin
                tx_valid_d = 1'b1;
                tx_bit_d   = par_d;
            end
`endif
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.tx_bit   = tx_bit_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx: directed frames plus randomized payloads
// compared against a bit-list model of the frame format.
module tb_sync_frame_tx;

    localparam int DATA_W = 8;
    localparam int SYNC_W = 4;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = SYNC_W + DATA_W + PAR_BITS;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1001;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic obs[$];

    sync_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    sync_frame_tx #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC(SYNC_PAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame as the wire should carry it: sync MSB-first, payload MSB-first, optional parity.
    function automatic void build_frame(input logic [DATA_W-1:0] d, output logic q[$]);
        q = {};
        for (int i = SYNC_W - 1; i >= 0; i--) q.push_back(SYNC_PAT[i]);
        for (int i = DATA_W - 1; i >= 0; i--) q.push_back(d[i]);
        if (PAR_BITS == 1) q.push_back(^d);
    endfunction

    // Sends one frame and checks every cycle of it plus DONE and the following IDLE cycle.
    // chained: start was already held high during the preceding IDLE cycle.
    // noise: scramble start/data_in while busy; otherwise hold start=next_chain and
    // switch data_in to next_d mid-frame.
    task automatic do_frame(input logic [DATA_W-1:0] d, input bit chained,
                            input bit next_chain, input logic [DATA_W-1:0] next_d,
                            input bit noise);
        logic exp_q[$];
        build_frame(d, exp_q);
        if (!chained) begin
            @(negedge clk);
            check("idle_ready", bus.ready, 1);
            bus.start   = 1'b1;
            bus.data_in = d;
        end
        obs = {};
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            check("tx_valid", bus.tx_valid, 1);
            check("tx_bit", bus.tx_bit, exp_q[i]);
            check("busy_frame", {bus.busy, bus.ready, bus.done}, 3'b100);
            obs.push_back(bus.tx_bit);
            if (i == FRAME_LEN - 1) begin
                bus.start   = next_chain;
                bus.data_in = next_d;
            end else if (noise) begin
                bus.start   = 1'($urandom);
                bus.data_in = DATA_W'($urandom);
            end else begin
                bus.start = next_chain;
                if (i == FRAME_LEN / 2) bus.data_in = next_d;
            end
        end
        @(negedge clk);
        check("done_cycle", {bus.done, bus.tx_valid, bus.tx_bit, bus.busy, bus.ready}, 5'b10010);
        @(negedge clk);
        check("after_done", {bus.done, bus.tx_valid, bus.busy, bus.ready}, 4'b0001);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits, pos;
        logic [3:0] hist;
        bit ch, nc;
        logic [DATA_W-1:0] cur, nd;

        // Reset and idle
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {bus.ready, bus.busy, bus.tx_valid, bus.tx_bit, bus.done}, 5'b10000);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_quiet", {bus.ready, bus.tx_valid, bus.tx_bit, bus.done}, 4'b1000);
        end

        // Single A5 frame, start for one cycle
        do_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
`ifdef SYNC_FRAME_TX_PARITY_EN
        check("parity_A5", obs[FRAME_LEN-1], 0);
        do_frame(8'h07, 1'b0, 1'b0, 8'h07, 1'b0);
        check("parity_07", obs[FRAME_LEN-1], 1);
`endif

        // 1001 detector on an all-zero payload: exactly one hit, on the 4th bit
        do_frame(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        hits = 0;
        pos  = -1;
        hist = '0;
        for (int i = 0; i < obs.size(); i++) begin
            hist = {hist[2:0], obs[i]};
            if (i >= 3 && hist == 4'b1001) begin
                hits++;
                pos = i;
            end
        end
        check("det_hits", hits, 1);
        check("det_pos", pos, 3);

        // Start held high, payload changed mid-frame, then back-to-back relaunch
        do_frame(8'hA5, 1'b0, 1'b1, 8'hFF, 1'b0);
        do_frame(8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0);

        // Reset during DATA bit 3
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 8'h5A;
        repeat (SYNC_W + 4) @(negedge clk);
        bus.start = 1'b0;
        check("pre_abort_valid", bus.tx_valid, 1);
        reset = 1'b0;
        #1;
        check("abort_outputs", {bus.tx_valid, bus.tx_bit, bus.busy, bus.ready, bus.done}, 5'b00010);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_idle", {bus.done, bus.tx_valid, bus.ready}, 3'b001);
        end
        do_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);

        // Randomized payloads with random chaining and noise on inputs while busy
        ch  = 1'b0;
        cur = DATA_W'($urandom);
        for (int k = 0; k < 24; k++) begin
            nc = (k < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            nd = DATA_W'($urandom);
            do_frame(cur, ch, nc, nd, 1'b1);
            ch  = nc;
            cur = nd;
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
